// File: rtl/mix_columns_pkg.sv
// Shared GF(2^8) helpers, FSM state type and parameter legality check
// for the sequential MixColumns engine.
package mix_columns_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Constant multipliers built from xtime chains; only the MixColumns set is supported.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   return a;
      8'h02:   return x2;
      8'h03:   return x2 ^ a;
      8'h09:   return x8 ^ a;
      8'h0B:   return x8 ^ x2 ^ a;
      8'h0D:   return x8 ^ x4 ^ a;
      8'h0E:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit nb_legal(input int unsigned nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column mixer, forward or inverse MixColumns.
module mix_column_unit
  import mix_columns_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a    [4];
  logic [7:0] coef [4];
  logic [7:0] acc;

  always_comb begin
    col_out = '0;
    acc     = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = col_in[31-8*i -: 8];
    end
    if (inv) begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    // Circulant: row r uses the base row rotated right by r.
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) begin
        acc = acc ^ gf_mul_const(a[c], coef[2'(c - r)]);
      end
      col_out[31-8*r -: 8] = acc;
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Multi-cycle MixColumns engine: mixes COLS_PER_CYCLE columns per clock over
// BEATS clocks, with valid/ready handshakes on both sides.
module mix_columns_seq
  import mix_columns_pkg::*;
#(
  parameter int unsigned NB             = 8,
  parameter int unsigned COLS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data
);

  localparam int unsigned BEATS  = NB / COLS_PER_CYCLE;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (!nb_legal(NB) || (NB % COLS_PER_CYCLE) != 0) begin : g_param_check
    $error("mix_columns_seq: NB must be 4, 6 or 8 and divisible by COLS_PER_CYCLE");
  end

  state_e              fsm_q, fsm_d;
  logic [32*NB-1:0]    state_q, state_d, out_q, out_d, mixed;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                inv_q, inv_d;
  logic [31:0]         unit_in  [COLS_PER_CYCLE];
  logic [31:0]         unit_out [COLS_PER_CYCLE];

  // Beat counter selects which column slice feeds the shared mixers.
  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      unit_in[k] = '0;
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == BEAT_W'(b)) begin
          unit_in[k] = state_q[32*NB-1-32*(b*COLS_PER_CYCLE+k) -: 32];
        end
      end
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
    mix_column_unit u_unit (
      .col_in  (unit_in[k]),
      .inv     (inv_q),
      .col_out (unit_out[k])
    );
  end

  always_comb begin
    mixed = state_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          mixed[32*NB-1-32*(b*COLS_PER_CYCLE+k) -: 32] = unit_out[k];
        end
      end
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    beat_d    = beat_q;
    inv_d     = inv_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fsm_d   = StBusy;
          state_d = in_data;
          inv_d   = in_inv;
          beat_d  = '0;
        end
      end
      StBusy: begin
        state_d = mixed;
        if (beat_q == LAST_BEAT) begin
          out_d = mixed;
          fsm_d = StDone;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            fsm_d   = StBusy;
            state_d = in_data;
            inv_d   = in_inv;
            beat_d  = '0;
          end else begin
            fsm_d = StIdle;
          end
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      out_q   <= '0;
      beat_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      out_q   <= out_d;
      beat_q  <= beat_d;
      inv_q   <= inv_d;
    end
  end

  assign out_data = out_q;

endmodule
